// File: rtl/irq_pkg.sv
// Shared constants and register map for irq_line_aggregator and its line synchroniser.
package irq_pkg;

  localparam logic [31:0] CAUSE_BASE = 32'h8000_0010;
  localparam int          IRQ_MAX    = 16;
  localparam int          IDX_W      = $clog2(IRQ_MAX);

  typedef enum logic [1:0] {
    ADDR_ENABLE    = 2'd0,
    ADDR_EDGE      = 2'd1,
    ADDR_PENDING   = 2'd2,
    ADDR_INSERVICE = 2'd3
  } cfg_addr_e;

endpackage

// File: rtl/irq_line_sync.sv
// One interrupt line: DEPTH-flop synchroniser followed by a rising-edge detector.
module irq_line_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic s_o,
  output logic rise_o
);

  logic [DEPTH-1:0] sync_q, sync_d;
  logic             hist_q, hist_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb sync_d = line_i;
    end else begin : g_chain
      always_comb sync_d = {sync_q[DEPTH-2:0], line_i};
    end
  endgenerate

  always_comb hist_d = sync_q[DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign s_o    = sync_q[DEPTH-1];
  assign rise_o = sync_q[DEPTH-1] & ~hist_q;

endmodule

// File: rtl/irq_line_aggregator.sv
// Collects peripheral interrupt lines into one registered request for interrupt_controller.
// Define IRQ_AGG_SYNC_EN for SYNC_STAGES-deep synchronisers; otherwise lines get one register stage.
module irq_line_aggregator
  import irq_pkg::*;
#(
  parameter int N_IRQ       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_lines_i,
  input  logic             irq_take_i,
  input  logic [31:0]      irq_cause_i,
  input  logic             irq_ret_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [N_IRQ-1:0] cfg_wdata_i,
  output logic [N_IRQ-1:0] cfg_rdata_o,
  output logic             irq_req_o,
  output logic [N_IRQ-1:0] irq_pending_o
);

`ifdef IRQ_AGG_SYNC_EN
  localparam int SYNC_DEPTH = SYNC_STAGES;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  generate
    if (N_IRQ < 1 || N_IRQ > IRQ_MAX || SYNC_STAGES < 2) begin : g_param_check
      $error("irq_line_aggregator: N_IRQ must be 1..16 and SYNC_STAGES >= 2");
    end
  endgenerate

  logic [N_IRQ-1:0] s_w, rise_w;

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
      irq_line_sync #(.DEPTH(SYNC_DEPTH)) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (irq_lines_i[gi]),
        .s_o    (s_w[gi]),
        .rise_o (rise_w[gi])
      );
    end
  endgenerate

  logic [N_IRQ-1:0] enable_q, enable_d;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] pend_edge_q, pend_edge_d;
  logic [N_IRQ-1:0] inservice_q, inservice_d;
  logic [IDX_W-1:0] active_idx_q, active_idx_d;
  logic             active_vld_q, active_vld_d;
  logic             irq_req_q, irq_req_d;

  logic [31:0]      cause_off;
  logic             take_vld;
  logic [IDX_W-1:0] take_idx;
  cfg_addr_e        cfg_addr;
  logic [N_IRQ-1:0] pending, w1c, take_oh, ret_oh;

  always_comb begin
    cause_off = irq_cause_i - CAUSE_BASE;
    take_vld  = irq_take_i & irq_cause_i[31] & (cause_off < 32'(N_IRQ));
    take_idx  = cause_off[IDX_W-1:0];
    cfg_addr  = cfg_addr_e'(cfg_addr_i);

    // Level lines mirror the synchronised input; edge lines use the latch.
    pending   = (pend_edge_q & edge_q) | (s_w & ~edge_q);

    enable_d  = enable_q;
    edge_d    = edge_q;
    w1c       = '0;
    if (cfg_we_i) begin
      case (cfg_addr)
        ADDR_ENABLE:  enable_d = cfg_wdata_i;
        ADDR_EDGE:    edge_d   = cfg_wdata_i;
        ADDR_PENDING: w1c      = cfg_wdata_i;
        default:      ;
      endcase
    end

    take_oh = '0;
    ret_oh  = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      take_oh[i] = take_vld && (take_idx == IDX_W'(i));
      ret_oh[i]  = irq_ret_i && active_vld_q && (active_idx_q == IDX_W'(i));
    end

    // Rise beats clears; masking with edge_q drops the latch when a line goes level.
    pend_edge_d  = edge_q & (rise_w | (pend_edge_q & ~(take_oh | w1c)));
    // Retire the old active line before recording a same-cycle take.
    inservice_d  = (inservice_q & ~ret_oh) | take_oh;
    active_idx_d = take_vld ? take_idx : active_idx_q;
    active_vld_d = take_vld ? 1'b1 : (irq_ret_i ? 1'b0 : active_vld_q);

    irq_req_d    = (|(pending & enable_q & ~inservice_q)) & ~active_vld_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q     <= '0;
      edge_q       <= '0;
      pend_edge_q  <= '0;
      inservice_q  <= '0;
      active_idx_q <= '0;
      active_vld_q <= 1'b0;
      irq_req_q    <= 1'b0;
    end else begin
      enable_q     <= enable_d;
      edge_q       <= edge_d;
      pend_edge_q  <= pend_edge_d;
      inservice_q  <= inservice_d;
      active_idx_q <= active_idx_d;
      active_vld_q <= active_vld_d;
      irq_req_q    <= irq_req_d;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg_addr)
      ADDR_ENABLE:    cfg_rdata_o = enable_q;
      ADDR_EDGE:      cfg_rdata_o = edge_q;
      ADDR_PENDING:   cfg_rdata_o = pending;
      ADDR_INSERVICE: cfg_rdata_o = inservice_q;
      default:        cfg_rdata_o = '0;
    endcase
  end

  assign irq_req_o     = irq_req_q;
  assign irq_pending_o = pending;

endmodule

// File: tb/tb_irq_line_aggregator.sv
// Directed bench for irq_line_aggregator: vector table with settle time plus timing corner sequences.
module tb_irq_line_aggregator;
  import irq_pkg::*;

`ifdef IRQ_AGG_SYNC_EN
  localparam int SDEPTH = 2;
`else
  localparam int SDEPTH = 1;
`endif
  localparam int LAT    = SDEPTH + 2;
  localparam int SETTLE = LAT + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lines = '0;
  logic        take = 1'b0;
  logic [31:0] cause = '0;
  logic        ret = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        req;
  logic [15:0] pend;

  int checks = 0;
  int failures = 0;

  irq_line_aggregator #(.N_IRQ(16), .SYNC_STAGES(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .irq_lines_i   (lines),
    .irq_take_i    (take),
    .irq_cause_i   (cause),
    .irq_ret_i     (ret),
    .cfg_we_i      (we),
    .cfg_addr_i    (addr),
    .cfg_wdata_i   (wdata),
    .cfg_rdata_o   (rdata),
    .irq_req_o     (req),
    .irq_pending_o (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] lines;
    logic        take;
    logic [31:0] cause;
    logic        ret;
    logic [1:0]  rd;
    logic [15:0] exp_rd;
    logic [15:0] exp_pend;
    logic        exp_req;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_strobes();
    we = 1'b0; take = 1'b0; ret = 1'b0; cause = '0; wdata = '0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
    we = 1'b1; addr = a; wdata = d;
    step();
    clear_strobes();
  endtask

  initial begin
    // Rows: we, addr, wdata, lines, take, cause, ret, rd, exp_rd, exp_pend, exp_req
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 0, 32'h0, 0, 2'd0, 16'h0000, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 2'd0, 16'h0009, 16'h0000, 0, 32'h0, 0, 2'd0, 16'h0009, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 2'd1, 16'h0001, 16'h0000, 0, 32'h0, 0, 2'd1, 16'h0001, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0008, 0, 32'h0, 0, 2'd2, 16'h0008, 16'h0008, 1});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0008, 1, 32'h8000_0013, 0, 2'd3, 16'h0008, 16'h0008, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0008, 1, 32'h0000_0002, 0, 2'd3, 16'h0008, 16'h0008, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0008, 1, 32'h8000_0030, 0, 2'd3, 16'h0008, 16'h0008, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0008, 0, 32'h0, 1, 2'd3, 16'h0000, 16'h0008, 1});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0008, 0, 32'h0, 1, 2'd3, 16'h0000, 16'h0008, 1});
    vecs.push_back(vec_t'{1, 2'd3, 16'hFFFF, 16'h0008, 0, 32'h0, 0, 2'd3, 16'h0000, 16'h0008, 1});
    vecs.push_back(vec_t'{1, 2'd2, 16'h0008, 16'h0008, 0, 32'h0, 0, 2'd2, 16'h0008, 16'h0008, 1});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 0, 32'h0, 0, 2'd2, 16'h0000, 16'h0000, 0});
    vecs.push_back(vec_t'{1, 2'd1, 16'h0025, 16'h0000, 0, 32'h0, 0, 2'd1, 16'h0025, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0004, 0, 32'h0, 0, 2'd2, 16'h0004, 16'h0004, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 0, 32'h0, 0, 2'd2, 16'h0004, 16'h0004, 0});
    vecs.push_back(vec_t'{1, 2'd0, 16'h0004, 16'h0000, 0, 32'h0, 0, 2'd0, 16'h0004, 16'h0004, 1});
    vecs.push_back(vec_t'{1, 2'd0, 16'h0000, 16'h0000, 0, 32'h0, 0, 2'd2, 16'h0004, 16'h0004, 0});
    vecs.push_back(vec_t'{1, 2'd0, 16'h0004, 16'h0000, 0, 32'h0, 0, 2'd0, 16'h0004, 16'h0004, 1});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 1, 32'h8000_0012, 0, 2'd3, 16'h0004, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 0, 32'h0, 1, 2'd3, 16'h0000, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 1, 32'h8000_0012, 0, 2'd3, 16'h0004, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 1, 32'h8000_0013, 1, 2'd3, 16'h0008, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 0, 32'h0, 1, 2'd3, 16'h0000, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0004, 0, 32'h0, 0, 2'd2, 16'h0004, 16'h0004, 1});
    vecs.push_back(vec_t'{1, 2'd2, 16'h0004, 16'h0004, 0, 32'h0, 0, 2'd2, 16'h0000, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 0, 32'h0, 0, 2'd2, 16'h0000, 16'h0000, 0});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0004, 0, 32'h0, 0, 2'd2, 16'h0004, 16'h0004, 1});
    vecs.push_back(vec_t'{0, 2'd0, 16'h0000, 16'h0000, 0, 32'h0, 0, 2'd2, 16'h0004, 16'h0004, 1});
    vecs.push_back(vec_t'{1, 2'd1, 16'h0021, 16'h0000, 0, 32'h0, 0, 2'd1, 16'h0021, 16'h0000, 0});

    // Reset and check the reset state of every register and output.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("reset_reg%0d", a), 32'(rdata), 32'h0);
    end
    check("reset_req", 32'(req), 32'h0);
    check("reset_pend", 32'(pend), 32'h0);
    @(negedge clk);

    // Table: apply one cycle of stimulus, hold lines while settling, then read back.
    for (int v = 0; v < vecs.size(); v++) begin
      we = vecs[v].we; addr = vecs[v].addr; wdata = vecs[v].wdata;
      lines = vecs[v].lines; take = vecs[v].take; cause = vecs[v].cause; ret = vecs[v].ret;
      step();
      clear_strobes();
      repeat (SETTLE) step();
      addr = vecs[v].rd;
      #1;
      $display("vec %0d: rd%0d=0x%04h pend=0x%04h req=%0b", v, vecs[v].rd, rdata, pend, req);
      check($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_rd));
      check($sformatf("vec%0d_pend", v), 32'(pend), 32'(vecs[v].exp_pend));
      check($sformatf("vec%0d_req", v), 32'(req), 32'(vecs[v].exp_req));
    end

    // Edge-to-request latency on line 0 (EDGE is 0x0021 here).
    cfg_write(2'd0, 16'h0001);
    repeat (SETTLE) step();
    lines = 16'h0001;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      $display("latency edge %0d: pend0=%0b req=%0b", k, pend[0], req);
      check($sformatf("lat_req_k%0d", k), 32'(req), (k >= LAT) ? 32'h1 : 32'h0);
      check($sformatf("lat_pend_k%0d", k), 32'(pend[0]), (k >= LAT - 1) ? 32'h1 : 32'h0);
      @(negedge clk);
      lines = 16'h0000;
    end
    cfg_write(2'd2, 16'h0001);
    repeat (SETTLE) step();
    check("lat_cleared_pend", 32'(pend), 32'h0);

    // Set wins: rise on line 5 in the very cycle a W1C targets it.
    lines = 16'h0020;
    repeat (SDEPTH) step();
    we = 1'b1; addr = 2'd2; wdata = 16'h0020;
    @(posedge clk);
    #1;
    $display("setwins: pend=0x%04h", pend);
    check("setwins_pend5", 32'(pend[5]), 32'h1);
    @(negedge clk);
    clear_strobes();
    cfg_write(2'd2, 16'h0020);
    #1;
    check("w1c_after_setwins", 32'(pend[5]), 32'h0);
    lines = 16'h0000;
    repeat (SETTLE) step();

    // Reset mid-service: line 0 in service, lines 1 and 2 latched pending.
    cfg_write(2'd1, 16'h0007);
    lines = 16'h0006;
    step();
    lines = 16'h0000;
    repeat (SETTLE) step();
    take = 1'b1; cause = 32'h8000_0010;
    step();
    clear_strobes();
    addr = 2'd3;
    #1;
    check("pre_reset_inservice", 32'(rdata), 32'h1);
    check("pre_reset_pend", 32'(pend), 32'h6);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("reset mid-service: pend=0x%04h req=%0b", pend, req);
    check("rst_req", 32'(req), 32'h0);
    check("rst_pend", 32'(pend), 32'h0);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      check($sformatf("rst_reg%0d", a), 32'(rdata), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
